sodor_instr_stim_gen: RTL and testbench

// - Synthesizable, seeded random instruction source for the Sodor 5-stage verification harness.
// - Drives the core imem response data in place of per-test behavioural generators.
// - Generalised to R-type, I-type ALU, load and mixed modes, with a configurable register range.
// - Provides a ready/valid handshake, warm-up NOPs, an instruction budget and a done flag.

---
 rtl/sodor_instr_stim_gen_pkg.sv | 37 +++
 rtl/sodor_instr_stim_gen_lfsr.sv | 40 ++++
 rtl/sodor_instr_stim_gen.sv | 158 +++++++++++++++
 tb/tb_sodor_instr_stim_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sodor_instr_stim_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sodor_stim_pkg
// Purpose  : Shared opcodes, mode/state enums and the LFSR step function for
//            the Sodor seeded random instruction source.
// Contents : OPC_RTYPE, OPC_ITYPE, OPC_LOAD, INSTR_NOP, LFSR_TAPS,
//            stim_mode_e, stim_state_e, lfsr_next()
// Revision : 1.0 - initial release
// ============================================================================
package sodor_stim_pkg;

    localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
    localparam logic [6:0]  OPC_ITYPE = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        MODE_R    = 2'd0,
        MODE_I    = 2'd1,
        MODE_LOAD = 2'd2,
        MODE_MIX  = 2'd3
    } stim_mode_e;

    typedef enum logic [1:0] {
        WARM = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stim_state_e;

    // Galois step: shift right, fold the taps back in when a one falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sodor_instr_stim_gen_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : stim_lfsr32
// Purpose  : 32-bit Galois LFSR that advances one step when 'step' is high.
// Ports    : clk, reset_n (sync, active-low), seed[31:0], step -> state[31:0]
// Revision : 1.0 - initial release
// ============================================================================
module stim_lfsr32
    import sodor_stim_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (step) begin
            state_d = lfsr_next(state_q);
        end
    end

    // An all-zero seed would lock the register, so it is replaced by 1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= (seed == 32'h0) ? 32'h1 : seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/sodor_instr_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : sodor_instr_stim_gen
// Purpose  : Seeded random RV32I instruction source with ready/valid output,
//            warm-up NOPs, optional instruction budget and sticky done flag.
// Ports    : clk, reset_n (sync, active-low), mode[1:0], instr_ready
//            -> instr_valid, instr[31:0], instr_count[CNT_W-1:0], done
// Revision : 1.0 - initial release
// ============================================================================
module sodor_instr_stim_gen
    import sodor_stim_pkg::*;
#(
    parameter logic [31:0] SEED          = 32'h0000_00E4,
    parameter int          NUM_REGS      = 32,
    parameter int          WARMUP_CYCLES = 2,
    parameter int          MAX_INSTRS    = 0,
    parameter logic [11:0] LOAD_IMM_MASK = 12'hFFF,
    parameter bit          ALLOW_ALT_F7  = 1'b1,
    parameter int          CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    input  logic             instr_ready,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [CNT_W-1:0] instr_count,
    output logic             done
);

    localparam logic [4:0]        REG_MASK  = 5'(NUM_REGS - 1);
    localparam int                WARM_W    = (WARMUP_CYCLES < 2) ? 1 : $clog2(WARMUP_CYCLES);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP_CYCLES == 0) ? 0 : WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_INSTRS);
    localparam bit                HAS_LIMIT = (MAX_INSTRS != 0);

    stim_state_e       state_q, state_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic [31:0]       lfsr_state;
    logic              lfsr_step;
    logic              accept;
    stim_mode_e        mode_e;

    assign mode_e = stim_mode_e'(mode);

    stim_lfsr32 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .seed    (SEED),
        .step    (lfsr_step),
        .state   (lfsr_state)
    );

    // Build one instruction word from an LFSR state and the requested mode.
    function automatic logic [31:0] encode(input logic [31:0] l, input stim_mode_e m);
        logic [4:0]  rs2, rs1, rd;
        logic [2:0]  f3;
        logic [11:0] imm, imm_i;
        logic [6:0]  f7;
        stim_mode_e  eff;
        logic [31:0] word;
        rs2   = l[4:0]   & REG_MASK;
        rs1   = l[9:5]   & REG_MASK;
        rd    = l[14:10] & REG_MASK;
        f3    = l[17:15];
        imm   = l[29:18];
        eff   = m;
        if (m == MODE_MIX) begin
            case (l[31:30])
                2'b00, 2'b01: eff = MODE_R;
                2'b10:        eff = MODE_I;
                default:      eff = MODE_LOAD;
            endcase
        end
        // Shift-immediate forms keep only shamt (and bit 30 for SRAI).
        imm_i = (f3 == 3'd1) ? (imm & 12'h01F) :
                (f3 == 3'd5) ? (imm & 12'h41F) : imm;
        f7    = (ALLOW_ALT_F7 && l[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'b0100000 : 7'b0;
        case (eff)
            MODE_R:  word = {f7, rs2, rs1, f3, rd, OPC_RTYPE};
            MODE_I:  word = {imm_i, rs1, f3, rd, OPC_ITYPE};
            default: word = {imm & LOAD_IMM_MASK, rs1, f3 & 3'b100, rd, OPC_LOAD};
        endcase
        return word;
    endfunction

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        count_d    = count_q;
        done_d     = done_q;
        lfsr_step  = 1'b0;
        accept     = valid_q && instr_ready;

        if (!valid_q) begin
            // valid is only low in the cycle right after reset.
            valid_d = 1'b1;
            if (WARMUP_CYCLES == 0) begin
                state_d = RUN;
                instr_d = encode(lfsr_state, mode_e);
            end
        end else if (accept) begin
            case (state_q)
                WARM: begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d = RUN;
                        instr_d = encode(lfsr_state, mode_e);
                    end
                end
                RUN: begin
                    lfsr_step = 1'b1;
                    count_d   = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                    if (HAS_LIMIT && (count_q + CNT_W'(1)) == CNT_LIMIT) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        instr_d = INSTR_NOP;
                    end else begin
                        // Encode from the state the LFSR is about to hold.
                        instr_d = encode(lfsr_next(lfsr_state), mode_e);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= WARM;
            warm_cnt_q <= '0;
            instr_q    <= INSTR_NOP;
            valid_q    <= 1'b0;
            count_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            done_q     <= done_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_count = count_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sodor_instr_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sodor_instr_stim_gen
// Purpose  : Self-checking bench for sodor_instr_stim_gen. Four instances with
//            different parameter sets share the inputs; a behavioural model
//            predicts every output of every instance each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sodor_instr_stim_gen;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Instance parameter sets: A, B, C, D
    localparam logic [31:0] SEED_A = 32'h0000_00E4, SEED_B = 32'h0, SEED_C = 32'h1, SEED_D = 32'h1234_5678;
    localparam int W_A = 3,  W_B = 2,  W_C = 2,  W_D = 0;
    localparam int N_A = 32, N_B = 16, N_C = 16, N_D = 8;
    localparam int M_A = 0,  M_B = 10, M_C = 10, M_D = 0;
    localparam logic [11:0] K_A = 12'hFFF, K_B = 12'h0FF, K_C = 12'h0FF, K_D = 12'hFFF;
    localparam bit F_A = 1'b1, F_B = 1'b0, F_C = 1'b0, F_D = 1'b1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ready;
    logic [1:0]  mode;
    logic [31:0] instr_o [4];
    logic        valid_o [4];
    logic [31:0] cnt_o   [4];
    logic        done_o  [4];

    always #5 clk = ~clk;

    sodor_instr_stim_gen #(.SEED(SEED_A), .NUM_REGS(N_A), .WARMUP_CYCLES(W_A), .MAX_INSTRS(M_A),
        .LOAD_IMM_MASK(K_A), .ALLOW_ALT_F7(F_A), .CNT_W(32)) u_a (
        .clk(clk), .reset_n(reset_n), .mode(mode), .instr_ready(ready),
        .instr_valid(valid_o[0]), .instr(instr_o[0]), .instr_count(cnt_o[0]), .done(done_o[0]));
    sodor_instr_stim_gen #(.SEED(SEED_B), .NUM_REGS(N_B), .WARMUP_CYCLES(W_B), .MAX_INSTRS(M_B),
        .LOAD_IMM_MASK(K_B), .ALLOW_ALT_F7(F_B), .CNT_W(32)) u_b (
        .clk(clk), .reset_n(reset_n), .mode(mode), .instr_ready(ready),
        .instr_valid(valid_o[1]), .instr(instr_o[1]), .instr_count(cnt_o[1]), .done(done_o[1]));
    sodor_instr_stim_gen #(.SEED(SEED_C), .NUM_REGS(N_C), .WARMUP_CYCLES(W_C), .MAX_INSTRS(M_C),
        .LOAD_IMM_MASK(K_C), .ALLOW_ALT_F7(F_C), .CNT_W(32)) u_c (
        .clk(clk), .reset_n(reset_n), .mode(mode), .instr_ready(ready),
        .instr_valid(valid_o[2]), .instr(instr_o[2]), .instr_count(cnt_o[2]), .done(done_o[2]));
    sodor_instr_stim_gen #(.SEED(SEED_D), .NUM_REGS(N_D), .WARMUP_CYCLES(W_D), .MAX_INSTRS(M_D),
        .LOAD_IMM_MASK(K_D), .ALLOW_ALT_F7(F_D), .CNT_W(32)) u_d (
        .clk(clk), .reset_n(reset_n), .mode(mode), .instr_ready(ready),
        .instr_valid(valid_o[3]), .instr(instr_o[3]), .instr_count(cnt_o[3]), .done(done_o[3]));

    // ---------------- reference model ----------------
    int          p_w [4], p_n [4], p_max [4];
    logic [31:0] p_seed [4];
    logic [11:0] p_mask [4];
    bit          p_alt [4];

    logic [31:0] m_L [4], m_instr [4];
    int          m_wacc [4], m_rand [4];
    logic        m_valid [4];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] adv(input logic [31:0] s);
        return (s % 2 == 1) ? ((s / 2) ^ 32'h8020_0003) : (s / 2);
    endfunction

    function automatic logic [31:0] enc(input int i, input logic [31:0] L, input logic [1:0] md);
        logic [31:0] n, rs2, rs1, rd, f3, imm, sel, f7, kind;
        n    = 32'(p_n[i]);
        rs2  = (L % 32) % n;
        rs1  = ((L >> 5) % 32) % n;
        rd   = ((L >> 10) % 32) % n;
        f3   = (L >> 15) % 8;
        imm  = (L >> 18) % 4096;
        sel  = L >> 30;
        kind = (md != 2'd3) ? 32'(md) : (sel < 2) ? 0 : (sel == 2) ? 1 : 2;
        if (kind == 0) begin
            f7 = (p_alt[i] && (sel % 2 == 1) && (f3 == 0 || f3 == 5)) ? 32 : 0;
            return (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h33;
        end else if (kind == 1) begin
            if (f3 == 1)      imm = imm % 32;
            else if (f3 == 5) imm = (imm % 32) + (imm & 32'h400);
            return (imm << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h13;
        end
        imm = imm & 32'(p_mask[i]);
        f3  = (f3 >= 4) ? 4 : 0;
        return (imm << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h03;
    endfunction

    function automatic bit m_done(input int i);
        return (p_max[i] != 0) && (m_rand[i] >= p_max[i]);
    endfunction

    function automatic logic [31:0] present(input int i, input logic [1:0] md);
        if (m_wacc[i] < p_w[i]) return NOP;
        if (m_done(i))          return NOP;
        return enc(i, m_L[i], md);
    endfunction

    task automatic model_update(input logic r, input logic rdy, input logic [1:0] md);
        for (int i = 0; i < 4; i++) begin
            if (!r) begin
                m_valid[i] = 1'b0;
                m_instr[i] = NOP;
                m_wacc[i]  = 0;
                m_rand[i]  = 0;
                m_L[i]     = (p_seed[i] == 0) ? 32'h1 : p_seed[i];
            end else if (!m_valid[i]) begin
                m_valid[i] = 1'b1;
                m_instr[i] = present(i, md);
            end else if (rdy) begin
                if (m_wacc[i] < p_w[i]) begin
                    m_wacc[i]++;
                end else if (!m_done(i)) begin
                    m_rand[i]++;
                    m_L[i] = adv(m_L[i]);
                end
                m_instr[i] = present(i, md);
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] @%0t: got %h, expected %h", nm, idx, $time, act, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk("instr", i, instr_o[i], m_instr[i]);
            chk("valid", i, 32'(valid_o[i]), 32'(m_valid[i]));
            chk("count", i, cnt_o[i], 32'(m_rand[i]));
            chk("done",  i, 32'(done_o[i]), 32'(m_done(i)));
        end
    endtask

    // Called just after a negedge: drive, clock, predict, then compare.
    task automatic tick(input logic r, input logic rdy, input logic [1:0] md);
        reset_n = r;
        ready   = rdy;
        mode    = md;
        @(posedge clk);
        model_update(r, rdy, md);
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        logic       rst_n;
        logic       rdy;
        logic [1:0] md;
        logic       exp_valid;
        logic       exp_nop;
        logic [6:0] exp_opc;
        int         exp_cnt;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] golden [8];
    logic [31:0] held;
    int          held_cnt;

    initial begin
        p_w    = '{W_A, W_B, W_C, W_D};
        p_n    = '{N_A, N_B, N_C, N_D};
        p_max  = '{M_A, M_B, M_C, M_D};
        p_seed = '{SEED_A, SEED_B, SEED_C, SEED_D};
        p_mask = '{K_A, K_B, K_C, K_D};
        p_alt  = '{F_A, F_B, F_C, F_D};

        // Reset then warm-up of instance A (3 NOPs, then R-type words).
        tbl[0] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 7'h13, 0};
        tbl[1] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 7'h13, 0};
        tbl[2] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 7'h13, 0};
        tbl[3] = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 7'h13, 0};
        tbl[4] = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 7'h13, 0};
        tbl[5] = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 7'h13, 0};
        tbl[6] = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 7'h33, 0};
        tbl[7] = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 7'h33, 1};

        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_instr[i] = NOP;
            m_wacc[i]  = 0;
            m_rand[i]  = 0;
            m_L[i]     = (p_seed[i] == 0) ? 32'h1 : p_seed[i];
        end

        reset_n = 1'b0;
        ready   = 1'b0;
        mode    = 2'd0;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            tick(tbl[k].rst_n, tbl[k].rdy, tbl[k].md);
            chk("tbl_valid", k, 32'(valid_o[0]), 32'(tbl[k].exp_valid));
            chk("tbl_opc",   k, 32'(instr_o[0][6:0]), 32'(tbl[k].exp_opc));
            if (tbl[k].exp_nop) chk("tbl_nop", k, instr_o[0], NOP);
            chk("tbl_cnt",   k, cnt_o[0], 32'(tbl[k].exp_cnt));
            chk("tbl_done",  k, 32'(done_o[0]), 32'h0);
            if (k >= 3) golden[k-3] = m_instr[0];
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1, 2'd0);
            golden[5+k] = m_instr[0];
        end

        // One-cycle reset after 7 accepts; the stream must replay exactly.
        tick(1'b0, 1'b1, 2'd0);
        chk("mrst_cnt",   0, cnt_o[0], 32'h0);
        chk("mrst_valid", 0, 32'(valid_o[0]), 32'h0);
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 1'b1, 2'd0);
            chk("replay", k, instr_o[0], golden[k]);
        end

        // Backpressure with mode wiggling: presented word and count hold.
        held     = m_instr[0];
        held_cnt = m_rand[0];
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 1'b0, 2'($urandom_range(0, 3)));
            chk("bp_instr", k, instr_o[0], held);
            chk("bp_cnt",   k, cnt_o[0], 32'(held_cnt));
        end
        for (int k = 0; k < 10; k++) tick(1'b1, 1'b1, 2'd0);

        // Budget on B/C (MAX 10); seed 0 and seed 1 must behave identically.
        tick(1'b0, 1'b0, 2'd0);
        tick(1'b0, 1'b0, 2'd0);
        for (int k = 0; k < 20; k++) tick(1'b1, 1'b1, 2'd3);
        for (int i = 1; i < 3; i++) begin
            chk("bud_done",  i, 32'(done_o[i]), 32'h1);
            chk("bud_cnt",   i, cnt_o[i], 32'd10);
            chk("bud_instr", i, instr_o[i], NOP);
        end

        // I-type shift-immediate masking and register range on D.
        tick(1'b0, 1'b1, 2'd1);
        for (int k = 0; k < 1000; k++) begin
            tick(1'b1, 1'b1, 2'd1);
            if (instr_o[0][6:0] == 7'h13 && instr_o[0][14:12] == 3'd1)
                chk("slli_f7", k, 32'(instr_o[0][31:25]), 32'h0);
            if (instr_o[0][6:0] == 7'h13 && instr_o[0][14:12] == 3'd5)
                chk("srxi_f7", k, 32'(instr_o[0][31:25] == 7'h00 || instr_o[0][31:25] == 7'h20), 32'h1);
            chk("d_rd_lt8",  k, 32'(instr_o[3][11:7]  < 5'd8), 32'h1);
            chk("d_rs1_lt8", k, 32'(instr_o[3][19:15] < 5'd8), 32'h1);
        end

        // Random ready, mode and occasional reset.
        tick(1'b0, 1'b0, 2'd0);
        for (int k = 0; k < 2000; k++) begin
            tick(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 9) < 7),
                 2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
